// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared glyph table, blank code and digit-index type for the
//               seg7 scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam int MAX_DIGITS = 8;

    typedef logic [$clog2(MAX_DIGITS)-1:0] digit_idx_t;

    // Active-high segment patterns {g,f,e,d,c,b,a} for hex 0..F
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_hex_lut.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_lut
// Description : Combinational nibble to active-high 7-segment glyph lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_lut
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_glyph
);

    assign o_glyph = GLYPH_TABLE[i_nibble];

endmodule : seg7_hex_lut
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Multiplexed N-digit hex driver for common-anode 7-segment
//               displays with tear-free value commit at frame boundaries.
//               Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] Value,
    input  logic                    Load,
    input  logic [NUM_DIGITS-1:0]   DigitEn,
    output logic [6:0]              Seg,
    output logic [NUM_DIGITS-1:0]   An,
    output logic                    Pending,
    output logic                    FrameDone
);

    localparam int               PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]    LAST_PRESC = PW'(CLK_DIV - 1);
    localparam digit_idx_t       LAST_IDX   = digit_idx_t'(NUM_DIGITS - 1);

    logic [PW-1:0]           r_presc;
    digit_idx_t              r_idx;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic                    r_pending;
    logic                    r_frame_done;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_term;
    logic                    w_wrap;
    logic [3:0]              w_nib;
    logic                    w_en;
    logic                    w_lz_blank;
    logic [NUM_DIGITS-1:0]   w_an;
    logic [6:0]              w_glyph;
    logic [6:0]              w_seg;

    assign w_term = (r_presc == LAST_PRESC);
    assign w_wrap = w_term && (r_idx == LAST_IDX);

    // Select the nibble, live enable and anode for the digit currently indexed
    always_comb begin
        w_nib = 4'h0;
        w_en  = 1'b0;
        w_an  = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == digit_idx_t'(i)) begin
                w_nib   = r_disp[4*i +: 4];
                w_en    = DigitEn[i];
                w_an[i] = 1'b0;
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic w_all_zero;

    // Walk down from the top nibble; blank while everything at or above is zero
    always_comb begin
        w_lz_blank = 1'b0;
        w_all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_all_zero = w_all_zero && (r_disp[4*i +: 4] == 4'h0);
            if ((r_idx == digit_idx_t'(i)) && w_all_zero) begin
                w_lz_blank = 1'b1;
            end
        end
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    seg7_hex_lut u_lut (
        .i_nibble (w_nib),
        .o_glyph  (w_glyph)
    );

    assign w_seg = (!w_en || w_lz_blank) ? ~SEG_BLANK : ~w_glyph;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_disp       <= '0;
            r_pend       <= '0;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
            r_seg        <= ~SEG_BLANK;
            r_an         <= '1;
        end else begin
            r_seg        <= w_seg;
            r_an         <= w_an;
            r_frame_done <= w_wrap;

            if (w_term) begin
                r_presc <= '0;
                r_idx   <= w_wrap ? '0 : r_idx + digit_idx_t'(1);
            end else begin
                r_presc <= r_presc + PW'(1);
            end

            if (Load) begin
                r_pend <= Value;
            end

            // A load coinciding with the boundary bypasses the pending stage
            if (w_wrap && Load) begin
                r_disp    <= Value;
                r_pending <= 1'b0;
            end else if (w_wrap && r_pending) begin
                r_disp    <= r_pend;
                r_pending <= 1'b0;
            end else if (Load) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign Seg       = r_seg;
    assign An        = r_an;
    assign Pending   = r_pending;
    assign FrameDone = r_frame_done;

endmodule : seg7_scan_driver
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver (4 digits, div 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Value;
    logic        Load;
    logic [3:0]  DigitEn;
    logic [6:0]  Seg;
    logic [3:0]  An;
    logic        Pending;
    logic        FrameDone;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: edges since reset release, committed and pending values
    int          m_t;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic        m_pending;

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      en;
        logic [3:0][6:0] exp;
    } vec_t;

    vec_t vecs[6];

    seg7_scan_driver #(
        .NUM_DIGITS (N),
        .CLK_DIV    (DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Value     (Value),
        .Load      (Load),
        .DigitEn   (DigitEn),
        .Seg       (Seg),
        .An        (An),
        .Pending   (Pending),
        .FrameDone (FrameDone)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;  default: glyph = 7'h71;
        endcase
    endfunction

    function automatic logic [6:0] render(input logic [15:0] disp, input int d,
                                          input logic [3:0] en);
        logic blank;
        blank = !en[d];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (d > 0 && (disp >> (4 * d)) == 16'h0) blank = 1'b1;
`endif
        render = blank ? 7'h7F : ~glyph(4'((disp >> (4 * d)) & 16'hF));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0d", name, act, exp, m_t);
        end
    endtask

    // One clock edge: predict from current inputs, then compare all outputs
    task automatic tick();
        int          t;
        int          d;
        logic [6:0]  es;
        logic [3:0]  ea;
        t  = m_t + 1;
        d  = ((t - 1) / DIV) % N;
        es = render(m_disp, d, DigitEn);
        ea = ~(4'b0001 << d);
        if (t % FRAME == 0) begin
            if (Load)           m_disp = Value;
            else if (m_pending) m_disp = m_pend;
            m_pending = 1'b0;
        end else if (Load) begin
            m_pend    = Value;
            m_pending = 1'b1;
        end
        m_t = t;
        @(posedge clk);
        #1;
        chk("seg",       {25'd0, Seg},       {25'd0, es});
        chk("an",        {28'd0, An},        {28'd0, ea});
        chk("pending",   {31'd0, Pending},   {31'd0, m_pending});
        chk("framedone", {31'd0, FrameDone}, {31'd0, (t % FRAME == 0)});
    endtask

    task automatic run_to(input int phase);
        for (int k = 0; k < FRAME && (m_t % FRAME) != phase; k++) tick();
    endtask

    task automatic model_reset();
        m_t       = 0;
        m_disp    = '0;
        m_pend    = '0;
        m_pending = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h1A2F, 4'b1111, {7'h79, 7'h08, 7'h24, 7'h0E}};
        vecs[1] = '{16'h8888, 4'b1011, {7'h00, 7'h7F, 7'h00, 7'h00}};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        vecs[2] = '{16'h0042, 4'b1111, {7'h7F, 7'h7F, 7'h19, 7'h24}};
        vecs[3] = '{16'h0000, 4'b1111, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[4] = '{16'h0705, 4'b1111, {7'h7F, 7'h78, 7'h40, 7'h12}};
`else
        vecs[2] = '{16'h0042, 4'b1111, {7'h40, 7'h40, 7'h19, 7'h24}};
        vecs[3] = '{16'h0000, 4'b1111, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[4] = '{16'h0705, 4'b1111, {7'h40, 7'h78, 7'h40, 7'h12}};
`endif
        vecs[5] = '{16'hBEEF, 4'b1111, {7'h03, 7'h06, 7'h06, 7'h0E}};

        rst = 1'b1; Load = 1'b0; Value = '0; DigitEn = 4'hF;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_seg",   {25'd0, Seg},       32'h7F);
        chk("rst_an",    {28'd0, An},        32'hF);
        chk("rst_pend",  {31'd0, Pending},   32'h0);
        chk("rst_frame", {31'd0, FrameDone}, 32'h0);
        rst = 1'b0;

        tick();
        chk("first_an",  {28'd0, An},  32'hE);
        chk("first_seg", {25'd0, Seg}, 32'h40);

        for (int v = 0; v < 6; v++) begin
            DigitEn = vecs[v].en;
            run_to(5);
            Value = vecs[v].value; Load = 1'b1;
            tick();
            Load = 1'b0;
            chk("vec_pending_set", {31'd0, Pending}, 32'h1);
            run_to(0);
            chk("vec_pending_clr", {31'd0, Pending}, 32'h0);
            for (int k = 0; k < FRAME; k++) begin
                tick();
                chk("vec_seg", {25'd0, Seg},
                    {25'd0, vecs[v].exp[((m_t - 1) / DIV) % N]});
            end
        end

        // Load landing exactly on the frame boundary commits immediately
        DigitEn = 4'hF;
        run_to(FRAME - 1);
        Value = 16'hBEEF; Load = 1'b1;
        tick();
        Load = 1'b0;
        chk("bnd_pending", {31'd0, Pending}, 32'h0);
        tick();
        chk("bnd_seg0", {25'd0, Seg}, 32'h0E);

        // Asynchronous reset while digit 2 is lit with a load pending
        run_to(8);
        Value = 16'h1234; Load = 1'b1;
        tick();
        Load = 1'b0;
        tick();
        chk("pre_rst_an", {28'd0, An}, 32'hB);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_an",   {28'd0, An},      32'hF);
        chk("mid_rst_seg",  {25'd0, Seg},     32'h7F);
        chk("mid_rst_pend", {31'd0, Pending}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        tick();
        chk("post_rst_seg", {25'd0, Seg}, 32'h40);
        run_to(0);
        tick();

        // Randomized loads, values and live blanking masks
        for (int c = 0; c < 600; c++) begin
            Load  = ($urandom_range(0, 5) == 0);
            Value = 16'($urandom);
            if ($urandom_range(0, 15) == 0) DigitEn = 4'($urandom);
            tick();
        end
        Load = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seg7_scan_driver
`default_nettype wire

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

- Multiplexed N-digit hexadecimal driver for common-anode 7-segment displays, successor to the single-digit combinational hex decoder.
- Latches a packed hex value, then time-multiplexes one shared segment bus across `NUM_DIGITS` digit enables with a programmable refresh prescaler.
- Value updates are tearing-free: a committed value never changes mid-frame.
- Sits between the calculator datapath result register and the board display pins.

## Interface
Parameters:
- `NUM_DIGITS`, 4: digits scanned; legal range 1–8.
- `CLK_DIV`, 50000: clock cycles each digit stays lit; legal ≥ 2.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `Value`  in  4*NUM_DIGITS: packed hex digits; nibble i drives digit i, digit 0 least significant.
- `Load`  in  1: capture strobe for `Value`.
- `DigitEn`  in  NUM_DIGITS: per-digit blank mask; 0 forces that digit blank. Sampled live, not latched.
- `Seg`  out  7: segments {g,f,e,d,c,b,a}, active-low (0 = lit).
- `An`  out  NUM_DIGITS: digit enables, active-low, one-hot-low while scanning.
- `Pending`  out  1: a loaded value is waiting for commit.
- `FrameDone`  out  1: one-cycle pulse when the scan wraps.

## Operation
Prescaler:
- Counts 0..CLK_DIV-1.
- At terminal count it returns to 0 and the digit index advances.

Digit index:
- Counts 0..NUM_DIGITS-1.
- Advancing from NUM_DIGITS-1 wraps to 0, which is the frame boundary.

Load and commit:
- `Load`=1 copies `Value` into the pending register and sets `Pending`.
- Consecutive loads overwrite the pending register; last one wins.
- At the frame boundary, if `Pending`=1, the pending register is copied into the display register and `Pending` clears.
- If `Load` and the frame boundary occur in the same cycle, the `Value` on that cycle is committed directly and `Pending` stays 0.

Glyphs (active-high form, then inverted onto `Seg`):
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
- 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Blank = 00, so `Seg`=7F.

A digit is shown blank when `DigitEn[i]`=0, or when it is suppressed by leading-zero blanking (see Configuration).

## Timing
- Reset values: prescaler 0, index 0, display and pending registers 0, `Pending`=0, `FrameDone`=0, `Seg`=7'h7F, `An`=all 1s.
- First cycle after reset release: `An`/`Seg` show digit 0 of the display register.
- `Seg` and `An` are registered and update together in the cycle after the index changes, so no ghosting.
- Each digit is lit for exactly CLK_DIV cycles; a frame is NUM_DIGITS*CLK_DIV cycles.
- `FrameDone` is asserted in the cycle where the index register becomes 0 after wrapping. It is not asserted at reset.
- Load-to-display latency: from 1 cycle (load on the boundary cycle) up to one frame plus 1 cycle.
- `rst` mid-frame clears everything immediately and drops any pending value.
- NUM_DIGITS=1: index stays 0, and `FrameDone` pulses every CLK_DIV cycles.

## Configuration
`SEG7_LEADING_ZERO_BLANK_EN`:
- Defined: any digit i>0 whose nibble and all higher nibbles in the display register are 0 is blanked. Digit 0 is always shown unless masked by `DigitEn`. Display register 0x0042 renders as "  42".
- Undefined: all digits are shown ("0042"), and no zero-detect logic is synthesised.

## Structure
- Package `seg7_pkg`:
  - 16-entry glyph constant array.
  - `SEG_BLANK` constant.
  - Digit-index typedef sized by `$clog2` of the max digit count.
- Sub-module `seg7_hex_lut`: purely combinational nibble→active-high glyph lookup from the package array. The driver applies blanking and inversion after it.

## Test plan
Bench uses NUM_DIGITS=4, CLK_DIV=4.
- Reset release → `Seg`=7F and `An`=1111 during reset; cycle 1: `An`=1110, `Seg`=~3F = 40. `FrameDone` first at cycle 16.
- `Load` with `Value`=16'h1A2F mid-frame → `Pending`=1 until the next boundary. In the next frame, digits 0..3 show ~71, ~5B, ~77, ~06 for 4 cycles each.
- `Load` asserted on the boundary cycle with 16'hBEEF → `Pending` stays 0, and digit 0 shows ~71 on the next cycle.
- `DigitEn`=4'b1011 with value 16'h8888 → digit 2 shows `Seg`=7F; the other digits show ~7F = 00.
- With `SEG7_LEADING_ZERO_BLANK_EN`, value 16'h0042 → digits 3 and 2 blank, digits 1 and 0 show "4" and "2". Value 16'h0000 → only digit 0 shows "0". Without the macro, "0042" is shown.
- Assert `rst` while digit 2 is lit with a load pending → `An`=1111, and after release the display register is 0 and `Pending`=0.
